// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer: start detect, bit timing, datapath strobes, result pulses
module uart_rx_ctrl #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          RX_IN,
    input  logic                          PAR_EN,
    input  logic                          sampled_bit,
    input  logic                          par_err,
    output logic [$clog2(PRESCALE)-1:0]   edge_cnt,
    output logic [3:0]                    bit_cnt,
    output logic                          dat_samp_en,
    output logic                          deser_en,
    output logic                          par_chk_en,
    output logic                          data_valid,
    output logic                          stp_err,
    output logic                          par_err_o,
    output logic                          strt_glitch,
    output logic                          busy
);

    localparam int            EW        = $clog2(PRESCALE);
    localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    logic   par_en_l;
    logic   bit_end;

    assign bit_end     = (edge_cnt == LAST_EDGE);
    assign dat_samp_en = (state != IDLE);
    assign busy        = (state != IDLE);
    assign deser_en    = (state == DATA) && bit_end;
    assign par_chk_en  = (state == PARITY) && bit_end;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            par_en_l    <= 1'b0;
            data_valid  <= 1'b0;
            stp_err     <= 1'b0;
            par_err_o   <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            stp_err     <= 1'b0;
            par_err_o   <= 1'b0;
            strt_glitch <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= bit_end ? '0 : edge_cnt + EW'(1);
            end

            case (state)
                IDLE: begin
                    // The detect cycle itself is edge 0 of the start bit.
                    if (!RX_IN) begin
                        state    <= START;
                        edge_cnt <= EW'(1);
                    end else begin
                        edge_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (sampled_bit) begin
                            strt_glitch <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state    <= DATA;
                            bit_cnt  <= '0;
                            par_en_l <= PAR_EN;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Parity and stop failures are reported independently and may coincide.
                    if (bit_end) begin
                        data_valid <= ~(par_en_l & par_err) & sampled_bit;
                        stp_err    <= ~sampled_bit;
                        par_err_o  <= par_en_l & par_err;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
